// File: rtl/redirect_ctrl_pkg.sv
// Shared types and constants for the redirect/trap unit: FSM state, machine CSR
// addresses and the default trap-vector reset value.
package redirect_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [31:0] MTVEC_RESET_DEF = 32'h8000_0100;

endpackage

// File: rtl/redirect_ctrl_csr.sv
// Machine trap CSRs (mtvec, mepc, mcause): qualified write decode plus trap
// capture of the faulting PC and cause.
module redirect_csr
    import redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = MTVEC_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [11:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_trap,
    input  logic [31:0] i_trap_pc,
    input  logic [7:0]  i_trap_cause,
    output logic [31:0] o_mtvec,
    output logic [31:0] o_mepc,
    output logic [7:0]  o_mcause
);

    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [7:0]  r_mcause;

    // The caller never asserts i_we together with i_trap, so the order below
    // only matters for readability.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtvec  <= MTVEC_RESET;
            r_mepc   <= 32'h0;
            r_mcause <= 8'h0;
        end else if (i_trap) begin
            r_mepc   <= {i_trap_pc[31:2], 2'b00};
            r_mcause <= i_trap_cause;
        end else if (i_we) begin
            case (i_addr)
                CSR_MTVEC:  r_mtvec  <= {i_wdata[31:2], 2'b00};
                CSR_MEPC:   r_mepc   <= {i_wdata[31:2], 2'b00};
                CSR_MCAUSE: r_mcause <= i_wdata[7:0];
                default:    ;
            endcase
        end
    end

    assign o_mtvec  = r_mtvec;
    assign o_mepc   = r_mepc;
    assign o_mcause = r_mcause;

endmodule

// File: rtl/redirect_ctrl.sv
// Commit-side redirect controller: prioritises exception > mret > mispredict,
// pulses fetch and holds flush. Optional REDIRECT_PERF_EN adds event counters.
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] MTVEC_RESET  = MTVEC_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_mispredict,
    input  logic [31:0] commit_target,
    input  logic        commit_exception,
    input  logic [7:0]  commit_mcause,
    input  logic        commit_mret,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic        commit_ready,
    output logic        mispredicted,
    output logic [31:0] pc_update,
    output logic        exception,
    output logic        mret,
    output logic [31:0] mtvec_ReadData,
    output logic [31:0] mepc_ReadData,
    output logic [7:0]  mcause,
`ifdef REDIRECT_PERF_EN
    output logic [31:0] mispredict_count,
    output logic [31:0] trap_count,
`endif
    output logic        flush
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic        r_misp;
    logic        r_exc;
    logic        r_mret;
    logic        r_flush;
    logic [31:0] r_pc_update;

    logic w_idle;
    logic w_event;
    logic w_take_exc;
    logic w_take_mret;
    logic w_take_misp;
    logic w_csr_we;

    assign w_idle      = (r_state == IDLE);
    assign w_event     = w_idle & commit_valid &
                         (commit_exception | commit_mret | commit_mispredict);
    assign w_take_exc  = w_event & commit_exception;
    assign w_take_mret = w_event & ~commit_exception & commit_mret;
    assign w_take_misp = w_event & ~commit_exception & ~commit_mret;
    assign w_csr_we    = w_idle & commit_valid & csr_we & ~commit_exception;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_ready     <= 1'b1;
            r_misp      <= 1'b0;
            r_exc       <= 1'b0;
            r_mret      <= 1'b0;
            r_flush     <= 1'b0;
            r_pc_update <= 32'h0;
        end else begin
            r_misp <= 1'b0;
            r_exc  <= 1'b0;
            r_mret <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_event) begin
                        r_exc   <= w_take_exc;
                        r_mret  <= w_take_mret;
                        r_misp  <= w_take_misp;
                        r_flush <= 1'b1;
                        r_ready <= 1'b0;
                        r_cnt   <= FLUSH_LOAD;
                        r_state <= FLUSH;
                        if (w_take_misp)
                            r_pc_update <= commit_target;
                    end
                end
                FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_flush <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    redirect_csr #(
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk          (clk),
        .reset        (reset),
        .i_we         (w_csr_we),
        .i_addr       (csr_addr),
        .i_wdata      (csr_wdata),
        .i_trap       (w_take_exc),
        .i_trap_pc    (commit_pc),
        .i_trap_cause (commit_mcause),
        .o_mtvec      (mtvec_ReadData),
        .o_mepc       (mepc_ReadData),
        .o_mcause     (mcause)
    );

`ifdef REDIRECT_PERF_EN
    logic [31:0] r_misp_count;
    logic [31:0] r_trap_count;

    // Counted at the edge that raises the pulse, so each pulse adds exactly one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misp_count <= 32'h0;
            r_trap_count <= 32'h0;
        end else begin
            if (w_take_misp)
                r_misp_count <= r_misp_count + 32'd1;
            if (w_take_exc)
                r_trap_count <= r_trap_count + 32'd1;
        end
    end

    assign mispredict_count = r_misp_count;
    assign trap_count       = r_trap_count;
`endif

    assign commit_ready = r_ready;
    assign mispredicted = r_misp;
    assign exception    = r_exc;
    assign mret         = r_mret;
    assign flush        = r_flush;
    assign pc_update    = r_pc_update;

endmodule
